// File: rtl/matmul_sched_pkg.sv
// Shared types and helpers for the matmul tile scheduler.
package matmul_sched_pkg;

    localparam int DEFAULT_M     = 3;
    localparam int DEFAULT_DIM_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD,
        S_START,
        S_COMPUTE,
        S_WRITEBACK,
        S_ADVANCE,
        S_FINISH
    } sched_state_t;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/matmul_tile_counter.sv
// Nested tile coordinate counters (tk innermost, then tc, then tr) with
// per-axis element bases, last-tile flags and edge-trimmed extents.
module matmul_tile_counter
    import matmul_sched_pkg::*;
#(
    parameter int M     = DEFAULT_M,
    parameter int DIM_W = DEFAULT_DIM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [DIM_W-1:0] cfg_rows,
    input  logic [DIM_W-1:0] cfg_inner,
    input  logic [DIM_W-1:0] cfg_cols,
    input  logic             init,
    input  logic             step_k,
    input  logic             step_rc,
    output logic             any_zero,
    output logic             first_k,
    output logic             last_k,
    output logic             last_c,
    output logic             last_r,
    output logic [DIM_W-1:0] base_r,
    output logic [DIM_W-1:0] base_k,
    output logic [DIM_W-1:0] base_c,
    output logic [DIM_W-1:0] ext_r,
    output logic [DIM_W-1:0] ext_k,
    output logic [DIM_W-1:0] ext_c
);

    localparam logic [DIM_W-1:0] M_W = DIM_W'(M);

    logic [DIM_W-1:0] rows_q, inner_q, cols_q;
    logic [DIM_W-1:0] n_r, n_k, n_c;
    logic [DIM_W-1:0] tr, tc, tk;
    logic [DIM_W-1:0] rem_r, rem_k, rem_c;

    // ceil(d / M) without forming d + M - 1, so dims up to the type max cannot overflow
    function automatic logic [DIM_W-1:0] tile_count(input logic [DIM_W-1:0] d);
        return (d / M_W) + DIM_W'((d % M_W) != '0);
    endfunction

    assign any_zero = (rows_q == '0) || (inner_q == '0) || (cols_q == '0);
    assign first_k  = (tk == '0);
    assign last_k   = (tk == n_k - DIM_W'(1));
    assign last_c   = (tc == n_c - DIM_W'(1));
    assign last_r   = (tr == n_r - DIM_W'(1));

    assign base_r = tr * M_W;
    assign base_k = tk * M_W;
    assign base_c = tc * M_W;

    assign rem_r = rows_q  - base_r;
    assign rem_k = inner_q - base_k;
    assign rem_c = cols_q  - base_c;

    assign ext_r = DIM_W'(min_u(32'(rem_r), M));
    assign ext_k = DIM_W'(min_u(32'(rem_k), M));
    assign ext_c = DIM_W'(min_u(32'(rem_c), M));

    // Latch dims on job start, size the tile grid at check, then walk tk/tc/tr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_q  <= '0;
            inner_q <= '0;
            cols_q  <= '0;
            n_r     <= '0;
            n_k     <= '0;
            n_c     <= '0;
            tr      <= '0;
            tc      <= '0;
            tk      <= '0;
        end else begin
            if (cfg_load) begin
                rows_q  <= cfg_rows;
                inner_q <= cfg_inner;
                cols_q  <= cfg_cols;
            end
            if (init) begin
                n_r <= tile_count(rows_q);
                n_k <= tile_count(inner_q);
                n_c <= tile_count(cols_q);
                tr  <= '0;
                tc  <= '0;
                tk  <= '0;
            end else if (step_k) begin
                tk <= tk + DIM_W'(1);
            end else if (step_rc) begin
                tk <= '0;
                if (last_c) begin
                    tc <= '0;
                    tr <= last_r ? '0 : tr + DIM_W'(1);
                end else begin
                    tc <= tc + DIM_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Control sequencer for C = A*W over an MxM tile engine: load, start,
// accumulate over inner tiles, write back each C tile, then advance.
module matmul_tile_scheduler
    import matmul_sched_pkg::*;
#(
    parameter int M     = DEFAULT_M,
    parameter int DIM_W = DEFAULT_DIM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [DIM_W-1:0] cfg_rows,
    input  logic [DIM_W-1:0] cfg_inner,
    input  logic [DIM_W-1:0] cfg_cols,
    input  logic             cfg_output_stationary,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ld_req,
    output logic [DIM_W-1:0] ld_row_base,
    output logic [DIM_W-1:0] ld_inner_base,
    output logic [DIM_W-1:0] ld_col_base,
    input  logic             ld_ack,
    output logic             tile_start,
    output logic [DIM_W-1:0] tile_k1,
    output logic [DIM_W-1:0] tile_k2,
    output logic [DIM_W-1:0] tile_k3,
    output logic             tile_os,
    output logic             tile_accumulate,
    input  logic             tile_done,
    output logic             wb_req,
    output logic [DIM_W-1:0] wb_row_base,
    output logic [DIM_W-1:0] wb_col_base,
    output logic [DIM_W-1:0] wb_rows,
    output logic [DIM_W-1:0] wb_cols,
    input  logic             wb_ack
);

    sched_state_t state_q, state_d;
    logic         os_q, err_q;
    logic         cfg_load, init, step_k, step_rc;
    logic         any_zero, first_k, last_k, last_c, last_r;
    logic [DIM_W-1:0] base_r, base_k, base_c, ext_r, ext_k, ext_c;

    matmul_tile_counter #(
        .M     (M),
        .DIM_W (DIM_W)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .cfg_load  (cfg_load),
        .cfg_rows  (cfg_rows),
        .cfg_inner (cfg_inner),
        .cfg_cols  (cfg_cols),
        .init      (init),
        .step_k    (step_k),
        .step_rc   (step_rc),
        .any_zero  (any_zero),
        .first_k   (first_k),
        .last_k    (last_k),
        .last_c    (last_c),
        .last_r    (last_r),
        .base_r    (base_r),
        .base_k    (base_k),
        .base_c    (base_c),
        .ext_r     (ext_r),
        .ext_k     (ext_k),
        .ext_c     (ext_c)
    );

    // State register plus the latched dataflow mode and zero-dim flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            os_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cfg_load) begin
                os_q <= cfg_output_stationary;
            end
            if (state_q == S_CHECK) begin
                err_q <= any_zero;
            end
        end
    end

    // Next-state and counter control; acks outside their waiting state fall through
    always_comb begin
        state_d  = state_q;
        cfg_load = 1'b0;
        init     = 1'b0;
        step_k   = 1'b0;
        step_rc  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    cfg_load = 1'b1;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                init    = 1'b1;
                state_d = any_zero ? S_FINISH : S_LOAD;
            end
            S_LOAD: begin
                if (ld_ack) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (tile_done) begin
                    if (last_k) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        step_k  = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_WRITEBACK: begin
                if (wb_ack) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                step_rc = 1'b1;
                state_d = (last_c && last_r) ? S_FINISH : S_LOAD;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done = (state_q == S_FINISH);
    assign err  = (state_q == S_FINISH) && err_q;

    assign ld_req        = (state_q == S_LOAD);
    assign ld_row_base   = base_r;
    assign ld_inner_base = base_k;
    assign ld_col_base   = base_c;

    assign tile_start      = (state_q == S_START);
    assign tile_k1         = tile_start ? ext_r : '0;
    assign tile_k2         = tile_start ? ext_k : '0;
    assign tile_k3         = tile_start ? ext_c : '0;
    assign tile_os         = os_q;
    assign tile_accumulate = tile_start && !first_k;

    assign wb_req      = (state_q == S_WRITEBACK);
    assign wb_row_base = base_r;
    assign wb_col_base = base_c;
    assign wb_rows     = wb_req ? ext_r : '0;
    assign wb_cols     = wb_req ? ext_c : '0;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Scoreboard bench for matmul_tile_scheduler: a loop-nest model queues the
// expected load/start/writeback/done events, the responder pops and compares.
module tb_matmul_tile_scheduler;

    localparam int M     = 3;
    localparam int DIM_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_start;
    logic [DIM_W-1:0] cfg_rows, cfg_inner, cfg_cols;
    logic             cfg_output_stationary;
    logic             busy, done, err;
    logic             ld_req, ld_ack;
    logic [DIM_W-1:0] ld_row_base, ld_inner_base, ld_col_base;
    logic             tile_start, tile_os, tile_accumulate, tile_done;
    logic [DIM_W-1:0] tile_k1, tile_k2, tile_k3;
    logic             wb_req, wb_ack;
    logic [DIM_W-1:0] wb_row_base, wb_col_base, wb_rows, wb_cols;

    int total = 0;
    int bad   = 0;
    logic [47:0]  exp_q[$];
    logic [127:0] outs;

    matmul_tile_scheduler #(.M(M), .DIM_W(DIM_W)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .cfg_start             (cfg_start),
        .cfg_rows              (cfg_rows),
        .cfg_inner             (cfg_inner),
        .cfg_cols              (cfg_cols),
        .cfg_output_stationary (cfg_output_stationary),
        .busy                  (busy),
        .done                  (done),
        .err                   (err),
        .ld_req                (ld_req),
        .ld_row_base           (ld_row_base),
        .ld_inner_base         (ld_inner_base),
        .ld_col_base           (ld_col_base),
        .ld_ack                (ld_ack),
        .tile_start            (tile_start),
        .tile_k1               (tile_k1),
        .tile_k2               (tile_k2),
        .tile_k3               (tile_k3),
        .tile_os               (tile_os),
        .tile_accumulate       (tile_accumulate),
        .tile_done             (tile_done),
        .wb_req                (wb_req),
        .wb_row_base           (wb_row_base),
        .wb_col_base           (wb_col_base),
        .wb_rows               (wb_rows),
        .wb_cols               (wb_cols),
        .wb_ack                (wb_ack)
    );

    always #5 clk = ~clk;

    assign outs = 128'({busy, done, err, ld_req, ld_row_base, ld_inner_base, ld_col_base,
                        tile_start, tile_k1, tile_k2, tile_k3, tile_os, tile_accumulate,
                        wb_req, wb_row_base, wb_col_base, wb_rows, wb_cols});

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int tmin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [47:0] mk_ev(input logic [7:0] kind, input logic [7:0] v0,
                                          input logic [7:0] v1, input logic [7:0] v2,
                                          input logic [7:0] v3, input logic [7:0] v4);
        return {kind, v0, v1, v2, v3, v4};
    endfunction

    function automatic logic [47:0] pop_exp();
        if (exp_q.size() == 0) return '1;
        return exp_q.pop_front();
    endfunction

    // Reference loop nest: rows outer, cols middle, inner innermost
    task automatic push_model(input int rows, input int inner, input int cols, input bit os,
                              output int n_ld, output int n_st, output int n_wb);
        int nr, nk, nc, k1, k2, k3;
        n_ld = 0; n_st = 0; n_wb = 0;
        if (rows == 0 || inner == 0 || cols == 0) begin
            exp_q.push_back(mk_ev(8'd4, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0));
            return;
        end
        nr = (rows + M - 1) / M;
        nk = (inner + M - 1) / M;
        nc = (cols + M - 1) / M;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                k1 = tmin(M, rows - r * M);
                k3 = tmin(M, cols - c * M);
                for (int k = 0; k < nk; k++) begin
                    k2 = tmin(M, inner - k * M);
                    exp_q.push_back(mk_ev(8'd1, 8'(r * M), 8'(k * M), 8'(c * M), 8'd0, 8'd0));
                    exp_q.push_back(mk_ev(8'd2, 8'(k1), 8'(k2), 8'(k3), 8'(k != 0), 8'(os)));
                    n_ld++;
                    n_st++;
                end
                exp_q.push_back(mk_ev(8'd3, 8'(r * M), 8'(c * M), 8'(k1), 8'(k3), 8'd0));
                n_wb++;
            end
        end
        exp_q.push_back(mk_ev(8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    endtask

    // Starts a job and plays the fetch unit, engine and store unit until done
    task automatic apply_stimulus(input string name, input int rows, input int inner, input int cols,
                                  input bit os, input int ack_dly, input int abort_at, input bit extra_start);
        int n_ld, n_st, n_wb;
        int c_ld = 0, c_st = 0, c_wb = 0;
        int ld_wait = 0, wb_wait = 0, td_cnt = 0;
        bit prev_ld = 0, prev_wb = 0, ld_acked = 0, abort_pending = 0, finished = 0, first_ld = 1;
        logic [23:0] ld_hold;
        logic [31:0] wb_hold;
        logic [47:0] e;

        push_model(rows, inner, cols, os, n_ld, n_st, n_wb);
        @(negedge clk);
        cfg_rows              = 8'(rows);
        cfg_inner             = 8'(inner);
        cfg_cols              = 8'(cols);
        cfg_output_stationary = os;
        cfg_start             = 1'b1;

        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            if (extra_start && cyc == 4) begin
                cfg_start = 1'b1;
                cfg_rows  = 8'd9;
                cfg_cols  = 8'd9;
            end
            ld_ack    = 1'b0;
            wb_ack    = 1'b0;
            tile_done = 1'b0;

            if (abort_pending) begin
                reset = 1'b0;
                #1;
                check_output({name, "/reset_outs"}, outs, 128'd0);
                exp_q.delete();
                finished = 1;
                break;
            end

            if (cyc == 1) check_output({name, "/busy_after_start"}, 128'(busy), 128'd1);
            if (busy) check_output({name, "/tile_os"}, 128'(tile_os), 128'(os));
            check_output({name, "/err_only_with_done"}, 128'(err & ~done), 128'd0);

            if (ld_req) begin
                if (!prev_ld) begin
                    c_ld++;
                    e = pop_exp();
                    check_output({name, "/ld"}, 128'(mk_ev(8'd1, ld_row_base, ld_inner_base, ld_col_base, 8'd0, 8'd0)), 128'(e));
                    if (first_ld) check_output({name, "/ld_latency"}, 128'(cyc), 128'd2);
                    first_ld = 0;
                    ld_hold  = {ld_row_base, ld_inner_base, ld_col_base};
                    ld_wait  = 0;
                end else begin
                    check_output({name, "/ld_hold"}, 128'({ld_row_base, ld_inner_base, ld_col_base}), 128'(ld_hold));
                end
                if (ld_wait == ack_dly) begin
                    ld_ack   = 1'b1;
                    ld_acked = 1;
                end
                ld_wait++;
            end
            prev_ld = ld_req;

            if (td_cnt > 0) begin
                td_cnt--;
                if (td_cnt == 0) tile_done = 1'b1;
            end
            if (tile_start) begin
                c_st++;
                check_output({name, "/start_after_ack"}, 128'(ld_acked), 128'd1);
                ld_acked = 0;
                e = pop_exp();
                check_output({name, "/start"}, 128'(mk_ev(8'd2, tile_k1, tile_k2, tile_k3, 8'(tile_accumulate), 8'(tile_os))), 128'(e));
                td_cnt = 2;
                if (abort_at != 0 && c_st == abort_at) abort_pending = 1;
            end

            if (wb_req) begin
                if (!prev_wb) begin
                    c_wb++;
                    e = pop_exp();
                    check_output({name, "/wb"}, 128'(mk_ev(8'd3, wb_row_base, wb_col_base, wb_rows, wb_cols, 8'd0)), 128'(e));
                    wb_hold = {wb_row_base, wb_col_base, wb_rows, wb_cols};
                    wb_wait = 0;
                end else begin
                    check_output({name, "/wb_hold"}, 128'({wb_row_base, wb_col_base, wb_rows, wb_cols}), 128'(wb_hold));
                end
                if (wb_wait == ack_dly) wb_ack = 1'b1;
                wb_wait++;
            end
            prev_wb = wb_req;

            if (done) begin
                e = pop_exp();
                check_output({name, "/done"}, 128'(mk_ev(8'd4, 8'(err), 8'd0, 8'd0, 8'd0, 8'd0)), 128'(e));
                check_output({name, "/busy_at_done"}, 128'(busy), 128'd0);
                if (n_ld == 0) check_output({name, "/done_latency"}, 128'(cyc), 128'd2);
                finished = 1;
                break;
            end
        end

        if (!finished) begin
            check_output({name, "/timeout"}, 128'(finished), 128'd1);
        end else if (abort_at == 0) begin
            check_output({name, "/ld_count"},   128'(c_ld), 128'(n_ld));
            check_output({name, "/st_count"},   128'(c_st), 128'(n_st));
            check_output({name, "/wb_count"},   128'(c_wb), 128'(n_wb));
            check_output({name, "/queue_empty"}, 128'(exp_q.size()), 128'd0);
        end
        exp_q.delete();
        @(negedge clk);
        ld_ack    = 1'b0;
        wb_ack    = 1'b0;
        tile_done = 1'b0;
        cfg_start = 1'b0;
    endtask

    initial begin
        reset                 = 1'b0;
        cfg_start             = 1'b0;
        cfg_rows              = '0;
        cfg_inner             = '0;
        cfg_cols              = '0;
        cfg_output_stationary = 1'b0;
        ld_ack                = 1'b0;
        tile_done             = 1'b0;
        wb_ack                = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_state", outs, 128'd0);
        reset = 1'b1;
        @(negedge clk);
        check_output("idle_after_reset", outs, 128'd0);

        $display("[TB] single 3x3x3 tile");
        apply_stimulus("t1", 3, 3, 3, 1'b0, 2, 0, 1'b0);

        $display("[TB] 5x4x7 multi-tile job");
        apply_stimulus("t2", 5, 4, 7, 1'b0, 2, 0, 1'b0);

        $display("[TB] zero inner dimension");
        apply_stimulus("t3", 3, 0, 3, 1'b0, 2, 0, 1'b0);

        $display("[TB] 2x3x2 output stationary with ignored restart");
        apply_stimulus("t4", 2, 3, 2, 1'b1, 1, 0, 1'b1);

        $display("[TB] reset during compute");
        apply_stimulus("t5", 5, 4, 7, 1'b0, 2, 5, 1'b0);
        check_output("t5/held_in_reset", outs, 128'd0);
        reset = 1'b1;
        @(negedge clk);
        tile_done = 1'b1;
        ld_ack    = 1'b1;
        wb_ack    = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        ld_ack    = 1'b0;
        wb_ack    = 1'b0;
        check_output("t5/late_acks_ignored", outs, 128'd0);
        @(negedge clk);
        check_output("t5/still_idle", outs, 128'd0);
        apply_stimulus("t5b", 3, 3, 3, 1'b0, 2, 0, 1'b0);

        $display("[TB] slow acknowledgements");
        apply_stimulus("t6", 4, 3, 3, 1'b0, 20, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
